// File: rtl/stack_arbiter.sv
// Two-requester arbiter in front of a push/pop stack datapath.
// One operation in flight; over/underflow rejected locally without a stack command.
//
// state | meaning
// IDLE  | grant one valid requester, round-robin when both are valid
// CMD   | single-cycle stk_req strobe carrying the latched op
// WAIT  | hold until stk_ack, then update occupancy
// RESP  | single-cycle rsp_valid with latched id/err/rdata
module stack_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rq0_valid,
    input  logic             rq0_push,
    input  logic [WIDTH-1:0] rq0_wdata,
    output logic             rq0_ready,
    input  logic             rq1_valid,
    input  logic             rq1_push,
    input  logic [WIDTH-1:0] rq1_wdata,
    output logic             rq1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             stk_req,
    output logic             stk_push,
    output logic [WIDTH-1:0] stk_wdata,
    input  logic             stk_ack,
    input  logic [WIDTH-1:0] stk_rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic             ptr;
    logic             grant_id;
    logic             grant_push;
    logic [WIDTH-1:0] grant_wdata;
    logic             xfer;
    logic             xfer_err;
    logic             op_id;
    logic             op_push;
    logic             op_err;
    logic [WIDTH-1:0] op_data;
    logic [WIDTH-1:0] rdata_q;
    logic [CW-1:0]    count_q;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign stk_push  = op_push;
    assign stk_wdata = op_data;
    assign rsp_id    = op_id;
    assign rsp_err   = op_err;
    assign rsp_rdata = rdata_q;

    always_comb begin
        grant_id    = (rq0_valid & rq1_valid) ? ptr : rq1_valid;
        grant_push  = grant_id ? rq1_push : rq0_push;
        grant_wdata = grant_id ? rq1_wdata : rq0_wdata;
        xfer_err    = grant_push ? full : empty;
        xfer        = 1'b0;
        rq0_ready   = 1'b0;
        rq1_ready   = 1'b0;
        stk_req     = 1'b0;
        rsp_valid   = 1'b0;
        state_nxt   = state;
        case (state)
            IDLE: begin
                // Gated by rst_n so no handshake is ever shown while in reset
                xfer      = rst_n & (rq0_valid | rq1_valid);
                rq0_ready = xfer & ~grant_id;
                rq1_ready = xfer & grant_id;
                if (xfer) state_nxt = xfer_err ? RESP : CMD;
            end
            CMD: begin
                stk_req   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (stk_ack) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= 1'b0;
            op_id   <= 1'b0;
            op_push <= 1'b0;
            op_err  <= 1'b0;
            op_data <= '0;
            rdata_q <= '0;
            count_q <= '0;
        end else begin
            if (xfer) begin
                ptr     <= ~grant_id;
                op_id   <= grant_id;
                op_push <= grant_push;
                op_data <= grant_wdata;
                op_err  <= xfer_err;
                rdata_q <= '0;
            end
            if (state == WAIT && stk_ack) begin
                if (!op_push) rdata_q <= stk_rdata;
                if (op_push && !full)       count_q <= count_q + CW'(1);
                else if (!op_push && !empty) count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter: stimulus queues expected responses,
// a negedge monitor pops and compares whenever rsp_valid is seen.
module tb_stack_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rq0_valid = 1'b0, rq0_push = 1'b0, rq0_ready;
    logic [7:0] rq0_wdata = 8'h00;
    logic       rq1_valid = 1'b0, rq1_push = 1'b0, rq1_ready;
    logic [7:0] rq1_wdata = 8'h00;
    logic       rsp_valid, rsp_id, rsp_err;
    logic [7:0] rsp_rdata;
    logic       stk_req, stk_push;
    logic [7:0] stk_wdata;
    logic       stk_ack = 1'b0;
    logic [7:0] stk_rdata = 8'h00;
    logic [2:0] count;
    logic       full, empty;

    stack_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_push(rq0_push), .rq0_wdata(rq0_wdata), .rq0_ready(rq0_ready),
        .rq1_valid(rq1_valid), .rq1_push(rq1_push), .rq1_wdata(rq1_wdata), .rq1_ready(rq1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .stk_req(stk_req), .stk_push(stk_push), .stk_wdata(stk_wdata),
        .stk_ack(stk_ack), .stk_rdata(stk_rdata),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic       err;
        logic [7:0] rd;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0;
    int   cyc = 0;
    int   rsp_seen = 0, rsp_cyc = 0;
    logic prev_rv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Stack datapath model: acks ack_dly cycles after the stk_req cycle
    logic [7:0] mem [0:7];
    int         sp = 0, timer = 0, ack_dly = 2;
    int         stk_cnt = 0, ack_cnt = 0, ack_cyc = 0;
    logic [7:0] pend_rd = 8'h00;

    always @(negedge clk) begin
        stk_ack   = 1'b0;
        stk_rdata = 8'h00;
        if (!rst_n) sp = 0;
        if (timer > 0) begin
            timer--;
            if (timer == 0) begin
                stk_ack   = 1'b1;
                stk_rdata = pend_rd;
                ack_cnt++;
                ack_cyc = cyc;
            end
        end
        if (stk_req === 1'b1) begin
            stk_cnt++;
            timer = ack_dly;
            if (stk_push) begin
                mem[sp[2:0]] = stk_wdata;
                if (sp < 7) sp++;
                pend_rd = 8'hEE;
            end else begin
                if (sp > 0) sp--;
                pend_rd = mem[sp[2:0]];
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            rsp_seen++;
            rsp_cyc = cyc;
            chk("rsp_pulse", 32'(prev_rv), 0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: id=%0d err=%0d rdata=%0h with nothing expected", rsp_id, rsp_err, rsp_rdata);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
            end
        end
        prev_rv = (rsp_valid === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_exp(input logic id, input logic err, input logic [7:0] rd);
        exp_t e;
        e.id = id;
        e.err = err;
        e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 60 && sb.size() != 0; n++) tick();
        chk(name, 32'(sb.size()), 0);
    endtask

    task automatic issue(input logic id, input logic push, input logic [7:0] data,
                         input logic eerr, input logic [7:0] erd);
        int seen0;
        bit got;
        tick();
        if (id) begin
            rq1_valid = 1'b1; rq1_push = push; rq1_wdata = data;
        end else begin
            rq0_valid = 1'b1; rq0_push = push; rq0_wdata = data;
        end
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if ((id ? rq1_ready : rq0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("grant_seen", 32'(got), 1);
        push_exp(id, eerr, erd);
        seen0 = rsp_seen;
        tick();
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        chk("ready_pulse", 32'(id ? rq1_ready : rq0_ready), 0);
        if (eerr) begin
            chk("err_no_cmd", 32'(stk_req), 0);
            chk("err_rsp_lat", 32'(rsp_valid), 1);
        end else begin
            chk("cmd_req", 32'(stk_req), 1);
            chk("cmd_push", 32'(stk_push), 32'(push));
            chk("cmd_wdata", 32'(stk_wdata), 32'(data));
        end
        for (int n = 0; n < 40 && rsp_seen == seen0; n++) tick();
        chk("rsp_arrived", 32'(rsp_seen - seen0), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s0, a0, seen0, grants, extra;
        bit  d0, d1, got;

        // Reset with both valids high: nothing may be granted
        rq0_valid = 1'b1;
        rq1_valid = 1'b1;
        rq0_push  = 1'b1;
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_stk_req", 32'(stk_req), 0);
        chk("rst_stk_push", 32'(stk_push), 0);
        chk("rst_stk_wdata", 32'(stk_wdata), 0);
        chk("rst_rq0_ready", 32'(rq0_ready), 0);
        chk("rst_rq1_ready", 32'(rq1_ready), 0);
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        rst_n = 1'b1;

        // Single push
        issue(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
        chk("a5_count", 32'(count), 1);
        chk("a5_empty", 32'(empty), 0);

        // Both pushing continuously: alternate grants, fill, then overflow
        do_reset();
        s0 = stk_cnt;
        for (int i = 0; i < 5; i++) push_exp(1'((i % 2) != 0), 1'(i == 4), 8'h00);
        tick();
        rq0_valid = 1'b1; rq0_push = 1'b1; rq0_wdata = 8'h10;
        rq1_valid = 1'b1; rq1_push = 1'b1; rq1_wdata = 8'h20;
        grants = 0;
        for (int n = 0; n < 200 && grants < 5; n++) begin
            #1;
            if (rq0_ready === 1'b1 || rq1_ready === 1'b1) begin
                chk("grant_alt", 32'(rq1_ready), 32'(grants % 2));
                chk("grant_onehot", 32'(rq0_ready & rq1_ready), 0);
                grants++;
            end
            tick();
        end
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        chk("fill_grants", 32'(grants), 5);
        drain("fill_drain");
        chk("fill_count", 32'(count), 4);
        chk("fill_full", 32'(full), 1);
        chk("fill_stk_cmds", 32'(stk_cnt - s0), 4);

        // LIFO order and underflow
        do_reset();
        issue(1'b0, 1'b1, 8'h11, 1'b0, 8'h00);
        issue(1'b0, 1'b1, 8'h22, 1'b0, 8'h00);
        issue(1'b1, 1'b0, 8'h00, 1'b0, 8'h22);
        issue(1'b1, 1'b0, 8'h00, 1'b0, 8'h11);
        issue(1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        chk("lifo_empty", 32'(empty), 1);
        chk("lifo_count", 32'(count), 0);

        // Simultaneous push/pop on empty: requester 0 first
        do_reset();
        push_exp(1'b0, 1'b0, 8'h00);
        push_exp(1'b1, 1'b0, 8'h33);
        tick();
        rq0_valid = 1'b1; rq0_push = 1'b1; rq0_wdata = 8'h33;
        rq1_valid = 1'b1; rq1_push = 1'b0; rq1_wdata = 8'h00;
        grants = 0; d0 = 1'b0; d1 = 1'b0;
        for (int n = 0; n < 200 && grants < 2; n++) begin
            #1;
            if (rq0_ready === 1'b1 || rq1_ready === 1'b1) begin
                chk("simul_order", 32'(rq1_ready), 32'(grants));
                if (rq1_ready) d1 = 1'b1;
                else           d0 = 1'b1;
                grants++;
            end
            tick();
            if (d0) rq0_valid = 1'b0;
            if (d1) rq1_valid = 1'b0;
        end
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        chk("simul_grants", 32'(grants), 2);
        drain("simul_drain");
        chk("simul_count", 32'(count), 0);

        // Reset during WAIT, ack arrives after release
        do_reset();
        ack_dly = 6;
        a0 = ack_cnt;
        seen0 = rsp_seen;
        tick();
        rq0_valid = 1'b1; rq0_push = 1'b1; rq0_wdata = 8'h5A;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (rq0_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("midrst_grant", 32'(got), 1);
        tick();
        rq0_valid = 1'b0;
        chk("midrst_cmd", 32'(stk_req), 1);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("midrst_no_rsp", 32'(rsp_seen - seen0), 0);
        chk("midrst_late_ack", 32'(ack_cnt - a0), 1);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        rq0_valid = 1'b1; rq0_push = 1'b1; rq0_wdata = 8'h66;
        #1;
        chk("midrst_idle", 32'(rq0_ready), 1);
        push_exp(1'b0, 1'b0, 8'h00);
        tick();
        rq0_valid = 1'b0;
        drain("midrst_drain");
        chk("midrst_count2", 32'(count), 1);

        // Slow stack: rq0 waits while rq1's push is outstanding
        ack_dly = 10;
        s0 = stk_cnt;
        push_exp(1'b1, 1'b0, 8'h00);
        push_exp(1'b0, 1'b0, 8'h77);
        tick();
        rq1_valid = 1'b1; rq1_push = 1'b1; rq1_wdata = 8'h77;
        rq0_valid = 1'b1; rq0_push = 1'b0; rq0_wdata = 8'h00;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (rq1_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("slow_grant_rq1", 32'(got), 1);
        seen0 = rsp_seen;
        extra = 0;
        tick();
        rq1_valid = 1'b0;
        for (int n = 0; n < 40 && rsp_seen == seen0; n++) begin
            if (rq0_ready === 1'b1 || rq1_ready === 1'b1) extra++;
            tick();
        end
        chk("slow_no_grant", 32'(extra), 0);
        chk("slow_one_cmd", 32'(stk_cnt - s0), 1);
        chk("slow_rsp_seen", 32'(rsp_seen - seen0), 1);
        chk("slow_rsp_lat", 32'(rsp_cyc - ack_cyc), 1);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rq0_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("slow_rq0_later", 32'(got), 1);
        tick();
        rq0_valid = 1'b0;
        drain("slow_drain");
        chk("slow_count", 32'(count), 1);
        ack_dly = 2;

        repeat (5) tick();
        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 256, stack capacity in words; CW = clog2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rq0_valid  input  1  requester 0 holds an operation.
REQ-006 rq0_push  input  1  requester 0 op: 1=push, 0=pop.
REQ-007 rq0_wdata  input  WIDTH  requester 0 push data.
REQ-008 rq0_ready  output  1  requester 0 operation accepted this cycle.
REQ-009 rq1_valid, rq1_push, rq1_wdata, rq1_ready  same as REQ-005..008 for requester 1.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_id  output  1  requester the response belongs to.
REQ-012 rsp_err  output  1  op rejected: push on full or pop on empty.
REQ-013 rsp_rdata  output  WIDTH  popped word; 0 for pushes and errors.
REQ-014 stk_req  output  1  one-cycle command strobe to stack datapath.
REQ-015 stk_push  output  1  command type: 1=push, 0=pop; valid with stk_req.
REQ-016 stk_wdata  output  WIDTH  push data; valid with stk_req.
REQ-017 stk_ack  input  1  stack completed the outstanding command.
REQ-018 stk_rdata  input  WIDTH  pop data; valid with stk_ack.
REQ-019 count  output  CW  current occupancy; full/empty  output  1 each  count==DEPTH / count==0.

Function
REQ-020 FSM states IDLE, CMD, WAIT, RESP; exactly one operation in flight.
REQ-021 IDLE: rqN_ready asserted combinationally for the granted requester only, only in IDLE, only when its valid is high; transfer = valid & ready.
REQ-022 Arbitration: single valid wins; both valid -> round-robin pointer winner; pointer moves to the other requester after each grant; reset pointer = requester 0.
REQ-023 On transfer: latch id, op, data; if push & full or pop & empty -> RESP with rsp_err=1, no stack command, count unchanged; else -> CMD.
REQ-024 CMD: stk_req=1 for exactly one cycle with latched stk_push/stk_wdata -> WAIT.
REQ-025 WAIT: hold until stk_ack; on ack capture stk_rdata if pop, count +1 on push / -1 on pop -> RESP; stk_ack outside WAIT is ignored.
REQ-026 RESP: rsp_valid=1 one cycle with latched rsp_id/rsp_err/rsp_rdata -> IDLE; new grant no earlier than the following cycle.
REQ-027 Latency: transfer at cycle T, stk_req at T+1, ack at A >= T+2, rsp_valid at A+1; error path rsp_valid at T+1.
REQ-028 count never exceeds DEPTH nor wraps below 0; full/empty derived from registered count only.
REQ-029 Non-granted requester's valid may stay high; it is granted in a later IDLE cycle, never dropped.
REQ-030 rsp_rdata, stk_wdata, stk_push held stable outside their strobe cycles (no X propagation).

Reset
REQ-031 rst_n low at a rising edge: state=IDLE, count=0, empty=1, full=0, pointer=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_rdata=0, stk_req=0, stk_push=0, stk_wdata=0, rqN_ready=0.
REQ-032 Reset mid-operation (CMD/WAIT/RESP) abandons the operation without a response; a later stk_ack is ignored.

Verification (WIDTH=8, DEPTH=4, stack model acks 2 cycles after stk_req)
REQ-033 Reset, rq0 push 0xA5 -> rq0_ready 1 cycle, stk_req push 0xA5 next cycle, rsp_valid id=0 err=0, count=1, empty=0.
REQ-034 rq0 and rq1 both push continuously -> grants alternate 0,1,0,1; count=4, full=1; fifth push -> rsp_err=1, no stk_req, count stays 4.
REQ-035 Pushes 0x11,0x22 then rq1 pop twice -> rsp_rdata 0x22 then 0x11, id=1; third pop -> rsp_err=1, rsp_rdata=0, empty=1.
REQ-036 Simultaneous rq0 push 0x33 / rq1 pop on empty after reset -> rq0 granted first (pointer 0), then rq1 pop returns 0x33, count 0.
REQ-037 Assert rst_n low during WAIT, stk_ack arrives after release -> no rsp_valid, count=0, FSM in IDLE.
REQ-038 Stack model delays ack 10 cycles -> no new rqN_ready, single stk_req, rsp_valid exactly one cycle after ack.
